// File: rtl/mux_4_1_pkg.sv
// mux_4_1_sync shared types and constants.
// Lane-select enum and the data value used when the select is not a valid lane.
package mux_4_1_pkg;

  typedef enum logic [1:0] {
    SEL_LANE0 = 2'd0,
    SEL_LANE1 = 2'd1,
    SEL_LANE2 = 2'd2,
    SEL_LANE3 = 2'd3
  } mux_sel_t;

  localparam logic MUX_SEL_DEFAULT_DATA = 1'b0;

endpackage

// File: rtl/mux_4_1_core.sv
// mux_4_1_core: purely combinational 4:1 lane select.
// An X/Z select falls to the default branch and yields zero.
module mux_4_1_core
  import mux_4_1_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic [DATA_WIDTH-1:0] data_0_i,
  input  logic [DATA_WIDTH-1:0] data_1_i,
  input  logic [DATA_WIDTH-1:0] data_2_i,
  input  logic [DATA_WIDTH-1:0] data_3_i,
  input  logic [1:0]            select_i,
  output logic [DATA_WIDTH-1:0] data_sel_o
);

  always_comb begin
    data_sel_o = {DATA_WIDTH{MUX_SEL_DEFAULT_DATA}};
    case (mux_sel_t'(select_i))
      SEL_LANE0: data_sel_o = data_0_i;
      SEL_LANE1: data_sel_o = data_1_i;
      SEL_LANE2: data_sel_o = data_2_i;
      SEL_LANE3: data_sel_o = data_3_i;
      default:   data_sel_o = {DATA_WIDTH{MUX_SEL_DEFAULT_DATA}};
    endcase
  end

endmodule

// File: rtl/mux_4_1_sync.sv
// mux_4_1_sync: 4:1 mux with tri-state output and optional registered copy.
// Registered stage built only when MUX_4_1_SYNC_REG_OUT_EN is defined.
module mux_4_1_sync
  import mux_4_1_pkg::*;
#(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic [DATA_WIDTH-1:0] Data_0_In,
  input  logic [DATA_WIDTH-1:0] Data_1_In,
  input  logic [DATA_WIDTH-1:0] Data_2_In,
  input  logic [DATA_WIDTH-1:0] Data_3_In,
  input  logic [1:0]            Select_In,
  output tri   [DATA_WIDTH-1:0] MUX_Result_Data_Out,
  output logic [DATA_WIDTH-1:0] MUX_Result_Data_Reg_Out,
  output logic                  MUX_Result_Valid_Out
);

  logic [DATA_WIDTH-1:0] MUX_Data_Selected;

  mux_4_1_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .data_0_i   (Data_0_In),
    .data_1_i   (Data_1_In),
    .data_2_i   (Data_2_In),
    .data_3_i   (Data_3_In),
    .select_i   (Select_In),
    .data_sel_o (MUX_Data_Selected)
  );

  // X enable propagates as X through the conditional
  assign MUX_Result_Data_Out =
    Enable_In ? MUX_Data_Selected
              : {DATA_WIDTH{1'bz}};

`ifdef MUX_4_1_SYNC_REG_OUT_EN
  logic [DATA_WIDTH-1:0] data_reg_d;
  logic [DATA_WIDTH-1:0] data_reg_q;
  logic                  valid_d;
  logic                  valid_q;

  always_comb begin
    data_reg_d = data_reg_q;
    valid_d    = Enable_In;
    if (Enable_In) begin
      data_reg_d = MUX_Data_Selected;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      data_reg_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_reg_q <= data_reg_d;
      valid_q    <= valid_d;
    end
  end

  assign MUX_Result_Data_Reg_Out = data_reg_q;
  assign MUX_Result_Valid_Out    = valid_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst          = Clock_In ^ Reset_n_In;
  assign MUX_Result_Data_Reg_Out = '0;
  assign MUX_Result_Valid_Out    = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4_1_sync.sv
// tb_mux_4_1_sync: scoreboard bench for mux_4_1_sync.
// Expectations adapt to whether MUX_4_1_SYNC_REG_OUT_EN is defined.
module tb_mux_4_1_sync;

  localparam int W = 1;
`ifdef MUX_4_1_SYNC_REG_OUT_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] d;
    logic         v;
  } reg_exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   sel;
  wire  [W-1:0] y;
  logic [W-1:0] yr;
  logic         yv;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] comb_q[$];
  reg_exp_t     reg_q[$];
  logic [W-1:0] m_reg;
  logic         m_valid;
  logic [W-1:0] exp_c;
  reg_exp_t     exp_r;

  mux_4_1_sync #(
    .DATA_WIDTH (W)
  ) dut (
    .Clock_In                (clk),
    .Reset_n_In              (rst_n),
    .Enable_In               (en),
    .Data_0_In               (d0),
    .Data_1_In               (d1),
    .Data_2_In               (d2),
    .Data_3_In               (d3),
    .Select_In               (sel),
    .MUX_Result_Data_Out     (y),
    .MUX_Result_Data_Reg_Out (yr),
    .MUX_Result_Valid_Out    (yv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [W-1:0] model_sel(input logic [1:0] s);
    case (s)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      2'd3:    return d3;
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic e, input logic [3:0] lanes,
                       input logic [1:0] s);
    en  = e;
    d0  = W'(lanes[0]);
    d1  = W'(lanes[1]);
    d2  = W'(lanes[2]);
    d3  = W'(lanes[3]);
    sel = s;
    comb_q.push_back(e ? model_sel(s) : {W{1'bz}});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      m_valid = en;
      if (en) m_reg = model_sel(sel);
    end
    reg_q.push_back({REG_EN ? m_reg : W'(0), REG_EN ? m_valid : 1'b0});
    #1;
  endtask

  task automatic test_reset();
    m_reg   = '0;
    m_valid = 1'b0;
    rst_n   = 1'b1;
    drive(1'b1, 4'b0100, 2'd2);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (yr !== '0 || yv !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: got %b/%b want 0/0", yr, yv);
    end
    exp_c = comb_q.pop_front();
    tests_run++;
    if (y !== exp_c) begin
      tests_failed++;
      $display("FAIL reset_comb: got %b want %b", y, exp_c);
    end
    tick();
    exp_r = reg_q.pop_front();
    tests_run++;
    if (yr !== exp_r.d || yv !== exp_r.v) begin
      tests_failed++;
      $display("FAIL reset_held: got %b/%b want %b/%b",
               yr, yv, exp_r.d, exp_r.v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_disabled();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 4'($urandom), 2'($urandom));
      #1;
      exp_c = comb_q.pop_front();
      tests_run++;
      if (y !== exp_c) begin
        tests_failed++;
        $display("FAIL disabled_comb: got %b want %b", y, exp_c);
      end
      tick();
      exp_r = reg_q.pop_front();
      tests_run++;
      if (yr !== exp_r.d || yv !== exp_r.v) begin
        tests_failed++;
        $display("FAIL disabled_reg: got %b/%b want %b/%b",
                 yr, yv, exp_r.d, exp_r.v);
      end
    end
  endtask

  task automatic test_one_hot();
    logic [3:0] oh;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 2; p++) begin
        oh = 4'b0001 << k;
        @(negedge clk);
        drive(1'b1, (p == 1) ? ~oh : oh, 2'(k));
        #1;
        exp_c = comb_q.pop_front();
        tests_run++;
        if (y !== exp_c || y !== W'(p == 0)) begin
          tests_failed++;
          $display("FAIL one_hot_comb k=%0d p=%0d: got %b want %b",
                   k, p, y, exp_c);
        end
        tick();
        exp_r = reg_q.pop_front();
        tests_run++;
        if (yr !== exp_r.d || yv !== exp_r.v) begin
          tests_failed++;
          $display("FAIL one_hot_reg k=%0d p=%0d: got %b/%b want %b/%b",
                   k, p, yr, yv, exp_r.d, exp_r.v);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    drive(1'b1, 4'b1000, 2'd3);
    #1;
    exp_c = comb_q.pop_front();
    tick();
    exp_r = reg_q.pop_front();
    tests_run++;
    if (yr !== exp_r.d || yv !== exp_r.v) begin
      tests_failed++;
      $display("FAIL midrst_capture: got %b/%b want %b/%b",
               yr, yv, exp_r.d, exp_r.v);
    end
    #2;
    rst_n   = 1'b0;
    m_reg   = '0;
    m_valid = 1'b0;
    drive(1'b1, 4'b1000, 2'd3);
    #1;
    tests_run++;
    if (yr !== '0 || yv !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got %b/%b want 0/0", yr, yv);
    end
    exp_c = comb_q.pop_front();
    tests_run++;
    if (y !== exp_c || y !== W'(1)) begin
      tests_failed++;
      $display("FAIL midrst_comb: got %b want %b", y, exp_c);
    end
    tick();
    exp_r = reg_q.pop_front();
    tests_run++;
    if (yr !== exp_r.d || yv !== exp_r.v) begin
      tests_failed++;
      $display("FAIL midrst_held: got %b/%b want %b/%b",
               yr, yv, exp_r.d, exp_r.v);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hold();
    @(negedge clk);
    drive(1'b1, 4'b0010, 2'd1);
    #1;
    exp_c = comb_q.pop_front();
    tick();
    exp_r = reg_q.pop_front();
    tests_run++;
    if (yr !== exp_r.d || yv !== exp_r.v) begin
      tests_failed++;
      $display("FAIL hold_capture: got %b/%b want %b/%b",
               yr, yv, exp_r.d, exp_r.v);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 4'b0000, 2'd1);
      #1;
      exp_c = comb_q.pop_front();
      tests_run++;
      if (y !== exp_c) begin
        tests_failed++;
        $display("FAIL hold_comb: got %b want %b", y, exp_c);
      end
      tick();
      exp_r = reg_q.pop_front();
      tests_run++;
      if (yr !== exp_r.d || yv !== exp_r.v ||
          yr !== W'(REG_EN)) begin
        tests_failed++;
        $display("FAIL hold_reg: got %b/%b want %b/%b",
                 yr, yv, exp_r.d, exp_r.v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'($urandom), 4'($urandom), 2'($urandom));
      #1;
      exp_c = comb_q.pop_front();
      tests_run++;
      if (y !== exp_c) begin
        tests_failed++;
        $display("FAIL random_comb %0d: got %b want %b", i, y, exp_c);
      end
      tick();
      exp_r = reg_q.pop_front();
      tests_run++;
      if (yr !== exp_r.d || yv !== exp_r.v) begin
        tests_failed++;
        $display("FAIL random_reg %0d: got %b/%b want %b/%b",
                 i, yr, yv, exp_r.d, exp_r.v);
      end
    end
  endtask

  task automatic test_back_to_back();
    // select and data both move mid-cycle; the edge sees the later pair
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 4'b0101, 2'(i));
      #1;
      exp_c = comb_q.pop_front();
      #1;
      drive(1'b1, 4'($urandom), 2'(3 - i));
      #1;
      exp_c = comb_q.pop_front();
      tests_run++;
      if (y !== exp_c) begin
        tests_failed++;
        $display("FAIL b2b_comb %0d: got %b want %b", i, y, exp_c);
      end
      tick();
      exp_r = reg_q.pop_front();
      tests_run++;
      if (yr !== exp_r.d || yv !== exp_r.v) begin
        tests_failed++;
        $display("FAIL b2b_reg %0d: got %b/%b want %b/%b",
                 i, yr, yv, exp_r.d, exp_r.v);
      end
    end
  endtask

  initial begin
    en  = 1'b0;
    d0  = '0;
    d1  = '0;
    d2  = '0;
    d3  = '0;
    sel = 2'd0;
    test_reset();
    test_disabled();
    test_one_hot();
    test_reset_mid_run();
    test_hold();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
